// File: rtl/serial_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_adder_if                                            |
// | Description : Handshake/data bundle for serial_adder.                    |
// |               master drives start/a/b/cin and observes the result side;  |
// |               slave (the adder) does the reverse.                        |
// |   start  request pulse, sampled on rising clk                            |
// |   a, b   WIDTH-bit operands, cin carry-in (captured with start)          |
// |   busy   operation in progress                                          |
// |   done   one-cycle pulse when sum/cout are fresh                         |
// |   sum    WIDTH-bit result, cout carry out of MSB                         |
// |   ovf    signed overflow, present only with SERIAL_ADDER_OVF_EN          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_adder                                               |
// | Description : Bit-serial ripple adder. One full-adder cell and a carry   |
// |               flop add two WIDTH-bit operands LSB-first, one bit per     |
// |               clock, behind a start/busy/done handshake.                 |
// | Ports       : clk    system clock, rising edge                           |
// |               rst_n  asynchronous active-low reset                       |
// |               bus    serial_adder_if.slave (start, a, b, cin in;         |
// |                      busy, done, sum, cout [, ovf] out)                  |
// | Parameters  : WIDTH  operand/result width, 2..32                         |
// | Options     : define SERIAL_ADDER_OVF_EN to add the signed-overflow      |
// |               output ovf (carry into MSB xor carry out of MSB)           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  // Holds the WIDTH-1 low result bits gathered so far; the MSB is the
  // bit produced on the final edge and is merged in directly.
  logic [WIDTH-2:0] r_res_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_s;
  logic             w_c_next;
  logic [WIDTH-1:0] w_res_next;

  // The single full-adder cell.
  assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
  assign w_c_next   = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
  // New bit enters from the MSB side, so bit i ends at position i.
  assign w_res_next = {w_s, r_res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_res_sh <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          // start is ignored here; operands keep shifting undisturbed.
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_c      <= w_c_next;
          r_res_sh <= w_res_next[WIDTH-1:1];
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            // Only the completed result is published, so sum never shows
            // partial bits of an operation in flight.
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_res_next;
            r_cout  <= w_c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // r_c is the carry into the MSB at this point.
            r_ovf   <= r_c ^ w_c_next;
`endif
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_c      <= bus.cin;
            r_cnt    <= '0;
            r_res_sh <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule
`default_nettype wire
